// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared motor-drive types and default constants.
// Revision    : 1.0
// ============================================================================
package motor_pkg;

   localparam int DEF_CNT_W  = 10;
   localparam int DEF_PERIOD = 1000;
   localparam int DEF_STEP   = 8;

   // Commutation stage constants
   localparam logic DIR_FWD       = 1'b0;
   localparam logic DIR_REV       = 1'b1;
   localparam int   DEAD_TIME_CYC = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAMP    = 3'd1,
      ST_HOLD    = 3'd2,
      ST_REVERSE = 3'd3,
      ST_BRAKE   = 3'd4
   } ramp_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_period_counter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_period_counter
// Description : Free-running 0..PERIOD-1 counter with start/last strobes.
// Revision    : 1.0
// ============================================================================
module pwm_period_counter
   import motor_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int PERIOD = DEF_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] cnt,
   output logic             period_start,
   output logic             cnt_last
);

   localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_VAL) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt          = cnt_q;
   assign period_start = (cnt_q == '0);
   assign cnt_last     = (cnt_q == LAST_VAL);

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_gen
// Description : Slew-limited PWM generator with reversal and emergency brake.
// Revision    : 1.0
// ============================================================================
module pwm_ramp_gen
   import motor_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int PERIOD = DEF_PERIOD,
   parameter int STEP   = DEF_STEP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             estop,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_duty,
   input  logic             cmd_dir,
   output logic             pwm,
   output logic             dir,
   output logic             brake,
   output logic [CNT_W-1:0] duty_cur,
   output logic             period_start
);

   localparam logic [CNT_W:0] PERIOD_X = (CNT_W + 1)'(PERIOD);
   localparam logic [CNT_W:0] STEP_X   = (CNT_W + 1)'(STEP);

   ramp_state_e      state_q, state_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic             tdir_q, tdir_d;
   logic             dir_q, dir_d;
   logic             pwm_q, pwm_d;
   logic             brake_q, brake_d;

   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             accept;
   logic [CNT_W:0]   duty_x, target_x, cmd_x, up_x;
   logic [CNT_W:0]   ramp_x, to_zero_x, clamp_x;

   pwm_period_counter #(
      .CNT_W  (CNT_W),
      .PERIOD (PERIOD)
   ) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .cnt          (cnt),
      .period_start (period_start),
      .cnt_last     (cnt_last)
   );

   assign cmd_ready = !rst && !estop && (state_q != ST_REVERSE);
   assign accept    = cmd_valid && cmd_ready;

   // Ramp arithmetic carries one extra bit so neither direction can wrap.
   always_comb begin
      duty_x   = {1'b0, duty_q};
      target_x = {1'b0, target_q};
      cmd_x    = {1'b0, cmd_duty};
      up_x     = duty_x + STEP_X;
      clamp_x  = (cmd_x > PERIOD_X) ? PERIOD_X : cmd_x;
      to_zero_x = (duty_x >= STEP_X) ? (duty_x - STEP_X) : '0;
      if (duty_x < target_x) begin
         ramp_x = (up_x > target_x) ? target_x : up_x;
      end else begin
         ramp_x = (duty_x >= target_x + STEP_X) ? (duty_x - STEP_X) : target_x;
      end
   end

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      tdir_d   = tdir_q;
      dir_d    = dir_q;

      if (estop) begin
         state_d  = ST_BRAKE;
         duty_d   = '0;
         target_d = '0;
      end else if (accept) begin
         target_d = clamp_x[CNT_W-1:0];
         tdir_d   = cmd_dir;
         if (state_q == ST_BRAKE) begin
            dir_d   = cmd_dir;
            state_d = ST_RAMP;
         end else if (cmd_dir != dir_q) begin
            state_d = ST_REVERSE;
         end else begin
            state_d = ST_RAMP;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               duty_d   = '0;
               target_d = '0;
            end
            ST_RAMP: begin
               if (duty_q == target_q) begin
                  state_d = (target_q == '0) ? ST_IDLE : ST_HOLD;
               end else if (cnt_last) begin
                  duty_d = ramp_x[CNT_W-1:0];
               end
            end
            ST_REVERSE: begin
               // Direction flips only once a whole boundary has passed at zero duty.
               if (cnt_last) begin
                  if (duty_q == '0) begin
                     dir_d   = tdir_q;
                     state_d = ST_RAMP;
                  end else begin
                     duty_d = to_zero_x[CNT_W-1:0];
                  end
               end
            end
            default: ;
         endcase
      end

      pwm_d   = (state_d != ST_BRAKE) && (cnt < duty_q);
      brake_d = (state_d == ST_BRAKE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         target_q <= '0;
         tdir_q   <= 1'b0;
         dir_q    <= 1'b0;
         pwm_q    <= 1'b0;
         brake_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         tdir_q   <= tdir_d;
         dir_q    <= dir_d;
         pwm_q    <= pwm_d;
         brake_q  <= brake_d;
      end
   end

   assign pwm      = pwm_q;
   assign dir      = dir_q;
   assign brake    = brake_q;
   assign duty_cur = duty_q;

endmodule
`default_nettype wire
